// File: rtl/bus_regfile_pkg.sv
// Shared types for the microcode sequencer bus: transfer cycles, register
// selectors and post-increment requests, plus flag bit positions.
package bus_regfile_pkg;

   typedef enum logic [1:0] {
      CYCLE_NONE      = 2'd0,
      CYCLE_REG_FETCH = 2'd1,
      CYCLE_REG_WRITE = 2'd2
   } microcode_cycle;

   // Codes from REG_PCP upward belong to the PC/stack block and are ignored here.
   typedef enum logic [4:0] {
      REG_A, REG_B,
      REG_XP, REG_XH, REG_XL,
      REG_YP, REG_YH, REG_YL,
      REG_SPH, REG_SPL,
      REG_MX, REG_MY, REG_MSP,
      REG_IMM, REG_FLAGS, REG_ALU, REG_ALU_WITH_FLAGS,
      REG_PCP, REG_PCSH, REG_PCSL, REG_NBP, REG_NPP, REG_VECTOR
   } reg_type;

   typedef enum logic [2:0] {
      REG_NONE, REG_X_INC, REG_Y_INC, REG_SP_INC, REG_SP_DEC
   } reg_inc_type;

   localparam int FLAG_I = 3;
   localparam int FLAG_D = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   // True for the selectors that address the data RAM.
   function automatic logic is_memory_reg(input reg_type sel);
      return (sel == REG_MX) || (sel == REG_MY) || (sel == REG_MSP);
   endfunction

endpackage

// File: rtl/bus_regfile_source_mux.sv
// Combinational half of the bus responder: picks the source nibble for a
// fetch and forms the data-RAM address from whichever selector is active.
module bus_source_mux
   import bus_regfile_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 12
) (
   input  microcode_cycle            current_cycle,
   input  reg_type                   bus_input_selector,
   input  reg_type                   bus_output_selector,
   input  logic [3:0]                reg_a,
   input  logic [3:0]                reg_b,
   input  logic [3:0]                flags,
   input  logic [11:0]               x,
   input  logic [11:0]               y,
   input  logic [7:0]                sp,
   input  logic [3:0]                immediate,
   input  logic [3:0]                alu_result,
   input  logic [3:0]                memory_read_data,
   output logic [3:0]                source_value,
   output logic [RAM_ADDR_WIDTH-1:0] memory_addr
);

   reg_type     addr_sel;
   logic [11:0] full_addr;

   // Address follows the source on a fetch and the destination otherwise.
   always_comb begin
      addr_sel  = (current_cycle == CYCLE_REG_FETCH) ? bus_input_selector
                                                     : bus_output_selector;
      full_addr = x;
      case (addr_sel)
         REG_MY:  full_addr = y;
         REG_MSP: full_addr = {4'h0, sp};
         default: full_addr = x;
      endcase
      memory_addr = RAM_ADDR_WIDTH'(full_addr);
   end

   // Source nibble; unhandled selectors read as zero.
   always_comb begin
      source_value = 4'h0;
      case (bus_input_selector)
         REG_A:              source_value = reg_a;
         REG_B:              source_value = reg_b;
         REG_XP:             source_value = x[11:8];
         REG_XH:             source_value = x[7:4];
         REG_XL:             source_value = x[3:0];
         REG_YP:             source_value = y[11:8];
         REG_YH:             source_value = y[7:4];
         REG_YL:             source_value = y[3:0];
         REG_SPH:            source_value = sp[7:4];
         REG_SPL:            source_value = sp[3:0];
         REG_MX,
         REG_MY,
         REG_MSP:            source_value = memory_read_data;
         REG_IMM:            source_value = immediate;
         REG_FLAGS:          source_value = flags;
         REG_ALU,
         REG_ALU_WITH_FLAGS: source_value = alu_result;
         default:            source_value = 4'h0;
      endcase
   end

endmodule

// File: rtl/bus_regfile.sv
// Responder side of the sequencer bus. Protocol: the sequencer presents one
// CYCLE_REG_FETCH (source -> bus latch) followed by one CYCLE_REG_WRITE
// (bus latch -> destination, plus post-increment); there is no stall or
// handshake, each cycle completes on its own clock edge and transfers may
// run back to back. Owns A, B, X, Y, SP, flags and the data-RAM write port.
module bus_regfile
   import bus_regfile_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  microcode_cycle            current_cycle,
   input  reg_type                   bus_input_selector,
   input  reg_type                   bus_output_selector,
   input  reg_inc_type               increment_selector,
   input  logic [3:0]                immediate,
   input  logic [3:0]                alu_result,
   input  logic                      alu_zero,
   input  logic                      alu_carry,
   output logic [RAM_ADDR_WIDTH-1:0] memory_addr,
   input  logic [3:0]                memory_read_data,
   output logic [3:0]                memory_write_data,
   output logic                      memory_write_en,
   output logic [3:0]                bus_value,
   output logic                      zero,
   output logic                      carry,
   output logic [3:0]                reg_a,
   output logic [3:0]                reg_b,
   output logic [11:0]               x,
   output logic [11:0]               y,
   output logic [7:0]                sp
);

   logic [3:0]  flags;
   logic [3:0]  source_value;
   logic [11:0] x_next;
   logic [11:0] y_next;
   logic [7:0]  sp_next;

   bus_source_mux #(
      .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
   ) u_source_mux (
      .current_cycle       (current_cycle),
      .bus_input_selector  (bus_input_selector),
      .bus_output_selector (bus_output_selector),
      .reg_a               (reg_a),
      .reg_b               (reg_b),
      .flags               (flags),
      .x                   (x),
      .y                   (y),
      .sp                  (sp),
      .immediate           (immediate),
      .alu_result          (alu_result),
      .memory_read_data    (memory_read_data),
      .source_value        (source_value),
      .memory_addr         (memory_addr)
   );

   assign zero              = flags[FLAG_Z];
   assign carry             = flags[FLAG_C];
   assign memory_write_data = bus_value;

   // One-cycle strobe for a memory destination; held low while in reset so
   // a write caught by reset never reaches the RAM.
   always_comb begin
      memory_write_en = reset_n && (current_cycle == CYCLE_REG_WRITE)
                        && is_memory_reg(bus_output_selector);
   end

   // Pointer updates for a write cycle: the increment is taken from the
   // pre-write value, then the destination nibble overrides its slot, so a
   // collision keeps the written nibble and the carried-into neighbours.
   always_comb begin
      x_next  = x;
      y_next  = y;
      sp_next = sp;
      case (increment_selector)
         REG_X_INC:  x_next[7:0] = x[7:0] + 8'd1;
         REG_Y_INC:  y_next[7:0] = y[7:0] + 8'd1;
         REG_SP_INC: sp_next     = sp + 8'd1;
         REG_SP_DEC: sp_next     = sp - 8'd1;
         default:    ;
      endcase
      case (bus_output_selector)
         REG_XP:  x_next[11:8] = bus_value;
         REG_XH:  x_next[7:4]  = bus_value;
         REG_XL:  x_next[3:0]  = bus_value;
         REG_YP:  y_next[11:8] = bus_value;
         REG_YH:  y_next[7:4]  = bus_value;
         REG_YL:  y_next[3:0]  = bus_value;
         REG_SPH: sp_next[7:4] = bus_value;
         REG_SPL: sp_next[3:0] = bus_value;
         default: ;
      endcase
   end

   // Register file: latch on fetch, commit destination and increments on write.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         reg_a     <= 4'h0;
         reg_b     <= 4'h0;
         x         <= 12'h000;
         y         <= 12'h000;
         sp        <= 8'h00;
         flags     <= 4'h0;
         bus_value <= 4'h0;
      end else if (current_cycle == CYCLE_REG_FETCH) begin
         bus_value <= source_value;
         if (bus_input_selector == REG_ALU_WITH_FLAGS) begin
            flags[FLAG_Z] <= alu_zero;
            flags[FLAG_C] <= alu_carry;
         end
      end else if (current_cycle == CYCLE_REG_WRITE) begin
         x  <= x_next;
         y  <= y_next;
         sp <= sp_next;
         case (bus_output_selector)
            REG_A:     reg_a <= bus_value;
            REG_B:     reg_b <= bus_value;
            REG_FLAGS: flags <= bus_value;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_regfile.sv
// Bench for bus_regfile: a directed table of transfers with hand-computed
// results, a reset-during-write sequence, idle cycles, and random transfers
// checked against a nibble-level model of the register file and RAM.
module tb_bus_regfile;
   import bus_regfile_pkg::*;

   logic           clk = 1'b0;
   logic           reset_n;
   microcode_cycle cur_cycle;
   reg_type        in_sel;
   reg_type        out_sel;
   reg_inc_type    inc_sel;
   logic [3:0]     immediate;
   logic [3:0]     alu_result;
   logic           alu_zero;
   logic           alu_carry;
   logic [11:0]    memory_addr;
   logic [3:0]     memory_read_data;
   logic [3:0]     memory_write_data;
   logic           memory_write_en;
   logic [3:0]     bus_value;
   logic           zero;
   logic           carry;
   logic [3:0]     reg_a;
   logic [3:0]     reg_b;
   logic [11:0]    x;
   logic [11:0]    y;
   logic [7:0]     sp;

   bus_regfile #(.RAM_ADDR_WIDTH(12)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .current_cycle       (cur_cycle),
      .bus_input_selector  (in_sel),
      .bus_output_selector (out_sel),
      .increment_selector  (inc_sel),
      .immediate           (immediate),
      .alu_result          (alu_result),
      .alu_zero            (alu_zero),
      .alu_carry           (alu_carry),
      .memory_addr         (memory_addr),
      .memory_read_data    (memory_read_data),
      .memory_write_data   (memory_write_data),
      .memory_write_en     (memory_write_en),
      .bus_value           (bus_value),
      .zero                (zero),
      .carry               (carry),
      .reg_a               (reg_a),
      .reg_b               (reg_b),
      .x                   (x),
      .y                   (y),
      .sp                  (sp)
   );

   // ---------------- clock / RAM environment ----------------
   always #5 clk = ~clk;

   logic [3:0] ram [0:4095] = '{default: 4'h0};
   assign memory_read_data = ram[memory_addr];
   always @(posedge clk) if (memory_write_en) ram[memory_addr] <= memory_write_data;

   // ---------------- scoreboard ----------------
   int         total_checks = 0;
   int         pass_checks  = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else pass_checks++;
   endtask

   // ---------------- reference model ----------------
   logic [3:0]  m_a, m_b, m_flags, m_bus;
   logic [11:0] m_x, m_y;
   logic [7:0]  m_sp;
   logic [3:0]  m_mem [0:4095];

   function automatic logic [11:0] m_addr(input reg_type s);
      if (s == REG_MY) return m_y;
      if (s == REG_MSP) return 12'(m_sp);
      return m_x;
   endfunction

   function automatic logic [3:0] m_source(input reg_type s, input logic [3:0] imm,
                                           input logic [3:0] alu_r);
      case (s)
         REG_A:   return m_a;
         REG_B:   return m_b;
         REG_XP:  return 4'((m_x >> 8) & 12'hF);
         REG_XH:  return 4'((m_x >> 4) & 12'hF);
         REG_XL:  return 4'(m_x & 12'hF);
         REG_YP:  return 4'((m_y >> 8) & 12'hF);
         REG_YH:  return 4'((m_y >> 4) & 12'hF);
         REG_YL:  return 4'(m_y & 12'hF);
         REG_SPH: return 4'(m_sp >> 4);
         REG_SPL: return 4'(m_sp & 8'hF);
         REG_MX, REG_MY, REG_MSP: return m_mem[m_addr(s)];
         REG_IMM: return imm;
         REG_FLAGS: return m_flags;
         REG_ALU, REG_ALU_WITH_FLAGS: return alu_r;
         default: return 4'h0;
      endcase
   endfunction

   // Increment from the old value first, then the written nibble wins its slot.
   task automatic m_write(input reg_type d, input reg_inc_type inc);
      logic [11:0] waddr;
      logic [11:0] v;
      waddr = m_addr(d);
      v     = 12'(m_bus);
      case (inc)
         REG_X_INC:  m_x  = (m_x & 12'hF00) | ((m_x + 12'd1) & 12'h0FF);
         REG_Y_INC:  m_y  = (m_y & 12'hF00) | ((m_y + 12'd1) & 12'h0FF);
         REG_SP_INC: m_sp = m_sp + 8'd1;
         REG_SP_DEC: m_sp = m_sp - 8'd1;
         default: ;
      endcase
      case (d)
         REG_A:   m_a = m_bus;
         REG_B:   m_b = m_bus;
         REG_XP:  m_x = (m_x & 12'h0FF) | (v << 8);
         REG_XH:  m_x = (m_x & 12'hF0F) | (v << 4);
         REG_XL:  m_x = (m_x & 12'hFF0) | v;
         REG_YP:  m_y = (m_y & 12'h0FF) | (v << 8);
         REG_YH:  m_y = (m_y & 12'hF0F) | (v << 4);
         REG_YL:  m_y = (m_y & 12'hFF0) | v;
         REG_SPH: m_sp = (m_sp & 8'h0F) | 8'(m_bus << 4);
         REG_SPL: m_sp = (m_sp & 8'hF0) | 8'(m_bus);
         REG_MX, REG_MY, REG_MSP: m_mem[waddr] = m_bus;
         REG_FLAGS: m_flags = m_bus;
         default: ;
      endcase
   endtask

   task automatic m_reset();
      m_a = 0; m_b = 0; m_flags = 0; m_bus = 0; m_x = 0; m_y = 0; m_sp = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_a"}, reg_a, m_a);
      check({tag, "_b"}, reg_b, m_b);
      check({tag, "_x"}, x, m_x);
      check({tag, "_y"}, y, m_y);
      check({tag, "_sp"}, sp, m_sp);
      check({tag, "_zero"}, zero, m_flags[1]);
      check({tag, "_carry"}, carry, m_flags[0]);
      check({tag, "_bus"}, bus_value, m_bus);
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; cur_cycle = CYCLE_NONE;
      repeat (2) @(posedge clk);
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One fetch + write pair, checked against the model at every step.
   task automatic transfer(input reg_type src, input reg_type dst, input reg_inc_type inc,
                           input logic [3:0] imm, input logic [3:0] alu_r,
                           input logic az, input logic ac);
      @(negedge clk);
      cur_cycle = CYCLE_REG_FETCH; in_sel = src; out_sel = dst; inc_sel = inc;
      immediate = imm; alu_result = alu_r; alu_zero = az; alu_carry = ac;
      #1;
      check("fetch_addr", memory_addr, m_addr(src));
      check("fetch_we", memory_write_en, 1'b0);
      exp_q.push_back(m_source(src, imm, alu_r));
      if (src == REG_ALU_WITH_FLAGS) begin
         m_flags[1] = az;
         m_flags[0] = ac;
      end
      @(posedge clk); #1;
      m_bus = exp_q.pop_front();
      check("fetch_bus", bus_value, m_bus);
      check("fetch_zero", zero, m_flags[1]);
      check("fetch_carry", carry, m_flags[0]);
      @(negedge clk);
      cur_cycle = CYCLE_REG_WRITE;
      #1;
      check("write_we", memory_write_en, is_memory_reg(dst));
      check("write_addr", memory_addr, m_addr(dst));
      if (is_memory_reg(dst)) check("write_data", memory_write_data, m_bus);
      m_write(dst, inc);
      @(posedge clk); #1;
      check_regs("write");
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      reg_type     src;
      reg_type     dst;
      reg_inc_type inc;
      logic [3:0]  imm;
      logic [3:0]  alu_r;
      logic        az;
      logic        ac;
      logic [3:0]  exp_a;
      logic [3:0]  exp_b;
      logic [11:0] exp_x;
      logic [11:0] exp_y;
      logic [7:0]  exp_sp;
      logic [3:0]  exp_flags;
   } vec_t;

   vec_t vecs [31];

   initial begin
      int mism;
      reset_n = 1'b0; cur_cycle = CYCLE_NONE; in_sel = REG_A; out_sel = REG_A;
      inc_sel = REG_NONE; immediate = 0; alu_result = 0; alu_zero = 0; alu_carry = 0;
      for (int i = 0; i < 4096; i++) m_mem[i] = 4'h0;

      //           src        dst      inc         imm  alu z c   a     b     x       y       sp     flags
      vecs[0]  = '{REG_IMM,   REG_A,   REG_NONE,   4'h5, 0, 0, 0, 4'h5, 4'h0, 12'h000, 12'h000, 8'h00, 4'h0};
      vecs[1]  = '{REG_IMM,   REG_XP,  REG_NONE,   4'h1, 0, 0, 0, 4'h5, 4'h0, 12'h100, 12'h000, 8'h00, 4'h0};
      vecs[2]  = '{REG_IMM,   REG_XH,  REG_NONE,   4'h2, 0, 0, 0, 4'h5, 4'h0, 12'h120, 12'h000, 8'h00, 4'h0};
      vecs[3]  = '{REG_IMM,   REG_XL,  REG_NONE,   4'h3, 0, 0, 0, 4'h5, 4'h0, 12'h123, 12'h000, 8'h00, 4'h0};
      vecs[4]  = '{REG_A,     REG_MX,  REG_NONE,   4'h0, 0, 0, 0, 4'h5, 4'h0, 12'h123, 12'h000, 8'h00, 4'h0};
      vecs[5]  = '{REG_MX,    REG_B,   REG_NONE,   4'h0, 0, 0, 0, 4'h5, 4'h5, 12'h123, 12'h000, 8'h00, 4'h0};
      vecs[6]  = '{REG_IMM,   REG_XL,  REG_X_INC,  4'hF, 0, 0, 0, 4'h5, 4'h5, 12'h12F, 12'h000, 8'h00, 4'h0};
      vecs[7]  = '{REG_IMM,   REG_XL,  REG_X_INC,  4'h7, 0, 0, 0, 4'h5, 4'h5, 12'h137, 12'h000, 8'h00, 4'h0};
      vecs[8]  = '{REG_IMM,   REG_SPL, REG_NONE,   4'hF, 0, 0, 0, 4'h5, 4'h5, 12'h137, 12'h000, 8'h0F, 4'h0};
      vecs[9]  = '{REG_IMM,   REG_SPH, REG_NONE,   4'hF, 0, 0, 0, 4'h5, 4'h5, 12'h137, 12'h000, 8'hFF, 4'h0};
      vecs[10] = '{REG_IMM,   REG_MSP, REG_NONE,   4'h9, 0, 0, 0, 4'h5, 4'h5, 12'h137, 12'h000, 8'hFF, 4'h0};
      vecs[11] = '{REG_MSP,   REG_A,   REG_SP_INC, 4'h0, 0, 0, 0, 4'h9, 4'h5, 12'h137, 12'h000, 8'h00, 4'h0};
      vecs[12] = '{REG_IMM,   REG_YL,  REG_SP_DEC, 4'h0, 0, 0, 0, 4'h9, 4'h5, 12'h137, 12'h000, 8'hFF, 4'h0};
      vecs[13] = '{REG_IMM,   REG_FLAGS, REG_NONE, 4'h6, 0, 0, 0, 4'h9, 4'h5, 12'h137, 12'h000, 8'hFF, 4'h6};
      vecs[14] = '{REG_FLAGS, REG_B,   REG_NONE,   4'h0, 0, 0, 0, 4'h9, 4'h6, 12'h137, 12'h000, 8'hFF, 4'h6};
      vecs[15] = '{REG_IMM,   REG_PCP, REG_NONE,   4'h3, 0, 0, 0, 4'h9, 4'h6, 12'h137, 12'h000, 8'hFF, 4'h6};
      vecs[16] = '{REG_PCP,   REG_A,   REG_NONE,   4'h0, 0, 0, 0, 4'h0, 4'h6, 12'h137, 12'h000, 8'hFF, 4'h6};
      vecs[17] = '{REG_ALU_WITH_FLAGS, REG_YP, REG_NONE, 4'h0, 4'h0, 1, 1, 4'h0, 4'h6, 12'h137, 12'h000, 8'hFF, 4'h7};
      vecs[18] = '{REG_IMM,   REG_XP,  REG_NONE,   4'h0, 0, 0, 0, 4'h0, 4'h6, 12'h037, 12'h000, 8'hFF, 4'h7};
      vecs[19] = '{REG_IMM,   REG_XH,  REG_NONE,   4'hF, 0, 0, 0, 4'h0, 4'h6, 12'h0F7, 12'h000, 8'hFF, 4'h7};
      vecs[20] = '{REG_IMM,   REG_XL,  REG_NONE,   4'hF, 0, 0, 0, 4'h0, 4'h6, 12'h0FF, 12'h000, 8'hFF, 4'h7};
      vecs[21] = '{REG_IMM,   REG_MX,  REG_NONE,   4'hA, 0, 0, 0, 4'h0, 4'h6, 12'h0FF, 12'h000, 8'hFF, 4'h7};
      vecs[22] = '{REG_MX,    REG_B,   REG_X_INC,  4'h0, 0, 0, 0, 4'h0, 4'hA, 12'h000, 12'h000, 8'hFF, 4'h7};
      vecs[23] = '{REG_IMM,   REG_XP,  REG_NONE,   4'h3, 0, 0, 0, 4'h0, 4'hA, 12'h300, 12'h000, 8'hFF, 4'h7};
      vecs[24] = '{REG_IMM,   REG_XH,  REG_NONE,   4'hF, 0, 0, 0, 4'h0, 4'hA, 12'h3F0, 12'h000, 8'hFF, 4'h7};
      vecs[25] = '{REG_IMM,   REG_XL,  REG_NONE,   4'hF, 0, 0, 0, 4'h0, 4'hA, 12'h3FF, 12'h000, 8'hFF, 4'h7};
      vecs[26] = '{REG_MX,    REG_B,   REG_X_INC,  4'h0, 0, 0, 0, 4'h0, 4'h0, 12'h300, 12'h000, 8'hFF, 4'h7};
      vecs[27] = '{REG_IMM,   REG_YL,  REG_Y_INC,  4'h5, 0, 0, 0, 4'h0, 4'h0, 12'h300, 12'h005, 8'hFF, 4'h7};
      vecs[28] = '{REG_IMM,   REG_MY,  REG_Y_INC,  4'h4, 0, 0, 0, 4'h0, 4'h0, 12'h300, 12'h006, 8'hFF, 4'h7};
      vecs[29] = '{REG_IMM,   REG_YL,  REG_NONE,   4'h5, 0, 0, 0, 4'h0, 4'h0, 12'h300, 12'h005, 8'hFF, 4'h7};
      vecs[30] = '{REG_MY,    REG_A,   REG_NONE,   4'h0, 0, 0, 0, 4'h4, 4'h0, 12'h300, 12'h005, 8'hFF, 4'h7};

      // reset state
      do_reset();
      #1;
      check("reset_a", reg_a, 4'h0);
      check("reset_x", x, 12'h000);
      check("reset_sp", sp, 8'h00);
      check("reset_flags", {zero, carry}, 2'b00);
      check("reset_bus", bus_value, 4'h0);
      check("reset_we", memory_write_en, 1'b0);

      // directed table
      for (int i = 0; i < 31; i++) begin
         transfer(vecs[i].src, vecs[i].dst, vecs[i].inc, vecs[i].imm,
                  vecs[i].alu_r, vecs[i].az, vecs[i].ac);
         check($sformatf("vec%0d_a", i), reg_a, vecs[i].exp_a);
         check($sformatf("vec%0d_b", i), reg_b, vecs[i].exp_b);
         check($sformatf("vec%0d_x", i), x, vecs[i].exp_x);
         check($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
         check($sformatf("vec%0d_sp", i), sp, vecs[i].exp_sp);
         check($sformatf("vec%0d_zc", i), {zero, carry}, vecs[i].exp_flags[1:0]);
      end
      check("tbl_ram_123", ram[12'h123], 4'h5);
      check("tbl_ram_0ff", ram[12'h0FF], 4'hA);
      check("tbl_ram_005", ram[12'h005], 4'h4);

      // reset arriving in the write cycle of A->MX: strobe dropped, state cleared
      transfer(REG_IMM, REG_A, REG_NONE, 4'hC, 0, 0, 0);
      @(negedge clk);
      cur_cycle = CYCLE_REG_FETCH; in_sel = REG_A; out_sel = REG_MX; inc_sel = REG_X_INC;
      @(negedge clk);
      cur_cycle = CYCLE_REG_WRITE; reset_n = 1'b0;
      #1;
      check("rst_write_we", memory_write_en, 1'b0);
      @(posedge clk); #1;
      m_reset();
      check_regs("rst_write");
      check("rst_write_ram", ram[12'h300], 4'h0);
      @(negedge clk);
      reset_n = 1'b1; cur_cycle = CYCLE_NONE;

      // idle cycles: no strobe, no state change
      in_sel = REG_IMM; out_sel = REG_MX; inc_sel = REG_SP_DEC; immediate = 4'hF;
      repeat (2) begin
         #1;
         check("idle_we", memory_write_en, 1'b0);
         @(posedge clk); #1;
         check_regs("idle");
         @(negedge clk);
      end

      // random back-to-back transfers
      for (int n = 0; n < 400; n++) begin
         transfer(reg_type'($urandom_range(0, int'(REG_VECTOR))),
                  reg_type'($urandom_range(0, int'(REG_VECTOR))),
                  reg_inc_type'($urandom_range(0, 4)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      mism = 0;
      for (int i = 0; i < 4096; i++) if (ram[i] !== m_mem[i]) mism++;
      check("ram_image", mism, 0);

      $display("%0d/%0d checks passed", pass_checks, total_checks);
      $finish;
   end

endmodule
